dmem_arbiter: RTL

Shares the single-port data_memory between the pipeline MEM stage (CPU port) and a debug/program-loader port (DBG port).
- Sequences each access: write in one cycle, read in MEM_LAT cycles.
- Stalls the CPU while its access is pending or has lost arbitration.
- Bounds DBG starvation with a counter.
- Sits between the EX/MEM register outputs and data_memory; cpu_stall feeds the pipeline hazard/stall logic.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/arb_starve_counter.sv | 29 ++
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared encodings and sizing constants for the data-memory arbiter and its helpers.
package dmem_arb_pkg;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RD_WAIT = 1'b1;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    localparam int MEM_LAT_MAX = 4;
    localparam int LAT_W       = 3;
    localparam int STARVE_W    = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating event counter with synchronous clear and a saturation flag.
module arb_starve_counter #(
    parameter int W   = 4,
    parameter int MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign sat = (cnt >= MAX_V);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port data memory between the pipeline MEM stage and a debug port,
// sequencing multi-cycle reads and bounding debug starvation.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

    logic [0:0]          state;
    owner_e              owner;
    logic [LAT_W-1:0]    lat_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [STARVE_W-1:0] starve_cnt;
    logic                starve_sat;

    logic   idle;
    logic   cpu_eligible;
    logic   dbg_eligible;
    logic   dbg_win;
    logic   cpu_win;
    logic   issue;
    logic   issue_we;
    logic   capture;
    owner_e cap_owner;

    assign idle         = (state == ST_IDLE);
    assign cpu_eligible = cpu_req & ~cpu_rvalid;
    assign dbg_eligible = dbg_req & ~dbg_rvalid;

    // Reset gates the issue path so nothing reaches memory while rst is held low.
    assign dbg_win  = rst & idle & dbg_eligible & (starve_sat | ~cpu_eligible);
    assign cpu_win  = rst & idle & cpu_eligible & ~dbg_win;
    assign issue    = cpu_win | dbg_win;
    assign issue_we = dbg_win ? dbg_we : cpu_we;

    assign dbg_gnt   = dbg_win;
    assign cpu_stall = rst & cpu_req & ~(cpu_win & cpu_we) & ~cpu_rvalid;

    assign capture   = (issue & ~issue_we & (MEM_LAT == 1)) |
                       ((state == ST_RD_WAIT) & (lat_cnt == LAT_W'(1)));
    assign cap_owner = (state == ST_RD_WAIT) ? owner : (dbg_win ? OWN_DBG : OWN_CPU);

    // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (state == ST_RD_WAIT) begin
            mem_addr = addr_q;
            mem_read = 1'b1;
        end else if (issue) begin
            mem_addr  = dbg_win ? dbg_addr  : cpu_addr;
            mem_wdata = dbg_win ? dbg_wdata : cpu_wdata;
            mem_write = issue_we;
            mem_read  = ~issue_we;
        end
    end

    arb_starve_counter #(
        .W   (STARVE_W),
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (cpu_win & dbg_req),
        .clr (dbg_win),
        .cnt (starve_cnt),
        .sat (starve_sat)
    );

    // NOTE: the read-data holding registers are plain flops, so they are cleared by reset like the rest.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_CPU;
            lat_cnt    <= '0;
            addr_q     <= '0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= capture & (cap_owner == OWN_CPU);
            dbg_rvalid <= capture & (cap_owner == OWN_DBG);
            if (capture && cap_owner == OWN_CPU) cpu_rdata <= mem_rdata;
            if (capture && cap_owner == OWN_DBG) dbg_rdata <= mem_rdata;

            if (state == ST_IDLE) begin
                if (issue && !issue_we && MEM_LAT > 1) begin
                    state   <= ST_RD_WAIT;
                    lat_cnt <= LAT_INIT;
                    addr_q  <= mem_addr;
                    owner   <= dbg_win ? OWN_DBG : OWN_CPU;
                end
            end else begin
                lat_cnt <= lat_cnt - 1'b1;
                if (lat_cnt == LAT_W'(1)) state <= ST_IDLE;
            end
        end
    end

    logic unused_starve;
    assign unused_starve = ^starve_cnt;

endmodule
